// File: rtl/deser400_pkg.sv
// Shared constants and types for the deser400 phase-scan logic.
package deser400_pkg;

  localparam int NPHASE_DEF = 8;
  localparam int NCHAN      = 4;

  typedef enum logic [1:0] {
    CH_I,
    CH_II,
    CH_III,
    CH_IV
  } chan_t;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    SETTLE,
    SAMPLE,
    NEXT,
    APPLY,
    DONE
  } phscan_state_t;

endpackage

// File: rtl/deser400_phscan_best.sv
// Per-channel running minimum of the xorsum, remembering the phase it occurred at.
module deser400_phscan_best (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       cmp_en,
  input  logic       first,
  input  logic [3:0] phase,
  input  logic [7:0] sum,
  output logic [3:0] best_phase,
  output logic [7:0] best_sum
);

  // Strict less-than so that a tie keeps the earlier (lower) phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_phase <= 4'd0;
      best_sum   <= 8'd0;
    end else if (clear) begin
      best_phase <= 4'd0;
      best_sum   <= 8'd0;
    end else if (cmp_en && (first || (sum < best_sum))) begin
      best_phase <= phase;
      best_sum   <= sum;
    end
  end

endmodule

// File: rtl/deser400_phscan.sv
// Phase scanner: steps every masked channel through all phases, keeps the lowest
// xorsum per channel, then writes the winning phase back one channel at a time.
module deser400_phscan
  import deser400_pkg::*;
#(
  parameter int NPHASE     = NPHASE_DEF,
  parameter int SETTLE_MAX = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  chan_mask,
  input  logic [3:0]  settle,
  input  logic        pd_trig,
  input  logic [31:0] xorsum,
  output logic [3:0]  phwrite,
  output logic [3:0]  phdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] best_phase,
  output logic [31:0] best_sum
);

  localparam logic [3:0] PH_LAST    = 4'(NPHASE - 1);
  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_MAX);

  phscan_state_t state_reg, state_next;
  chan_t         chan_reg;
  logic [3:0]    mask_reg;
  logic [3:0]    settle_reg;
  logic [3:0]    phase_reg;
  logic [3:0]    trig_cnt_reg;
  logic          sampled_reg;
  logic [31:0]   xs_reg;
  logic          done_reg;

  logic          best_clear;
  logic          cmp_en;
  logic [3:0]    best_phase_ch [NCHAN];
  logic [7:0]    best_sum_ch   [NCHAN];

  always_comb begin
    state_next = state_reg;
    phwrite    = 4'd0;
    phdata     = 4'd0;
    best_clear = 1'b0;
    cmp_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          best_clear = 1'b1;
          state_next = (chan_mask == 4'd0) ? DONE : SET;
        end
      end
      SET: begin
        phwrite    = mask_reg;
        phdata     = phase_reg;
        state_next = (settle_reg == 4'd0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        if (pd_trig && (trig_cnt_reg == settle_reg - 4'd1)) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (sampled_reg) begin
          cmp_en     = 1'b1;
          state_next = NEXT;
        end
      end
      NEXT: begin
        state_next = (phase_reg == PH_LAST) ? APPLY : SET;
      end
      APPLY: begin
        if (mask_reg[chan_reg]) begin
          phwrite = 4'b0001 << chan_reg;
          phdata  = best_phase_ch[chan_reg];
        end
        if (chan_reg == CH_IV) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Abort overrides everything: no strobe and no compare in the abort cycle.
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      phwrite    = 4'd0;
      phdata     = 4'd0;
      cmp_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      chan_reg     <= CH_I;
      mask_reg     <= 4'd0;
      settle_reg   <= 4'd0;
      phase_reg    <= 4'd0;
      trig_cnt_reg <= 4'd0;
      sampled_reg  <= 1'b0;
      xs_reg       <= 32'd0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == DONE) && !abort;
      case (state_reg)
        IDLE: begin
          if (start && !abort) begin
            mask_reg   <= chan_mask;
            settle_reg <= (settle > SETTLE_LIM) ? SETTLE_LIM : settle;
            phase_reg  <= 4'd0;
          end
        end
        SET: begin
          trig_cnt_reg <= 4'd0;
          sampled_reg  <= 1'b0;
        end
        SETTLE: begin
          if (pd_trig) trig_cnt_reg <= trig_cnt_reg + 4'd1;
        end
        SAMPLE: begin
          if (!sampled_reg && pd_trig) begin
            xs_reg      <= xorsum;
            sampled_reg <= 1'b1;
          end
        end
        NEXT: begin
          if (phase_reg == PH_LAST) chan_reg <= CH_I;
          else                      phase_reg <= phase_reg + 4'd1;
        end
        APPLY: begin
          chan_reg <= chan_t'(chan_reg + 2'd1);
        end
        default: begin
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_best
      deser400_phscan_best u_best (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (best_clear),
        .cmp_en     (cmp_en && mask_reg[gi]),
        .first      (phase_reg == 4'd0),
        .phase      (phase_reg),
        .sum        (xs_reg[gi*8 +: 8]),
        .best_phase (best_phase_ch[gi]),
        .best_sum   (best_sum_ch[gi])
      );
      assign best_phase[gi*4 +: 4] = best_phase_ch[gi];
      assign best_sum[gi*8 +: 8]   = best_sum_ch[gi];
    end
  endgenerate

  assign busy = (state_reg != IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_deser400_phscan.sv
// Directed bench for deser400_phscan: each scan is driven cycle by cycle and checked with immediate assertions.
module tb_deser400_phscan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  chan_mask;
  logic [3:0]  settle;
  logic        pd_trig;
  logic [31:0] xorsum;
  logic [3:0]  phwrite;
  logic [3:0]  phdata;
  logic        busy;
  logic        done;
  logic [15:0] best_phase;
  logic [31:0] best_sum;

  deser400_phscan #(.NPHASE(8), .SETTLE_MAX(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .chan_mask  (chan_mask),
    .settle     (settle),
    .pd_trig    (pd_trig),
    .xorsum     (xorsum),
    .phwrite    (phwrite),
    .phdata     (phdata),
    .busy       (busy),
    .done       (done),
    .best_phase (best_phase),
    .best_sum   (best_sum)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] xs_tab [8];
  int          cyc, set_n, apply_n, done_n, done_cyc, bad_set, bad_data;
  int          first_ph, cur_phase, abort_cyc, abort_ph_v, restart_ph_v;
  int          trig_per, trig_ofs;
  bit          abort_pend, timeout;
  logic [3:0]  strobe_or, mask_cur;
  logic [3:0]  apply_bits [4];
  logic [3:0]  apply_data [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic trig_at(input int c);
    return (trig_per == 0) ? 1'b1 : ((c % trig_per) == trig_ofs);
  endfunction

  // One clock: observe outputs just after the edge, then drive next-cycle inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    if (abort_pend) begin
      abort      = 1'b1;
      abort_pend = 1'b0;
      abort_cyc  = cyc;
    end
    if (phwrite != 4'd0) begin
      strobe_or |= phwrite;
      if (set_n < 8) begin
        if (phwrite !== mask_cur) bad_set++;
        cur_phase = int'(phdata);
        if (set_n == 0) first_ph = int'(phdata);
        set_n++;
        if (int'(phdata) == abort_ph_v) abort_pend = 1'b1;
        if (int'(phdata) == restart_ph_v) begin
          start     = 1'b1;
          chan_mask = 4'hF;
        end
      end else begin
        if (apply_n < 4) begin
          apply_bits[apply_n] = phwrite;
          apply_data[apply_n] = phdata;
        end
        apply_n++;
      end
    end else if (phdata != 4'd0) begin
      bad_data++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
    pd_trig = trig_at(cyc);
    xorsum  = xs_tab[cur_phase];
  endtask

  task automatic run_scan(input string name, input logic [3:0] m, input logic [3:0] s,
                          input int tp, input int to, input int ab_ph, input int rs_ph,
                          input bit stop_apply, input int budget);
    int tail = -1;
    set_n = 0; apply_n = 0; done_n = 0; done_cyc = -1; bad_set = 0; bad_data = 0;
    first_ph = -1; cur_phase = 0; abort_pend = 1'b0; abort_cyc = -1; timeout = 1'b0;
    abort_ph_v = ab_ph; restart_ph_v = rs_ph; trig_per = tp; trig_ofs = to;
    strobe_or = 4'd0; mask_cur = m;
    cyc = 0; chan_mask = m; settle = s; start = 1'b1; abort = 1'b0;
    pd_trig = trig_at(0);
    xorsum  = xs_tab[0];
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_n > 0 && tail < 0) tail = 3;
      if (tail > 0) tail--;
      if (tail == 0) break;
      if (stop_apply && apply_n > 0) break;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) break;
    end
    timeout = !((done_n > 0) || (stop_apply && apply_n > 0) ||
                (abort_cyc >= 0 && cyc == abort_cyc + 1));
    $display("scan %s: mask=%b settle=%0d done_at=%0d applies=%0d best_phase=%h best_sum=%h",
             name, m, s, done_cyc, apply_n, best_phase, best_sum);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; chan_mask = 4'd0; settle = 4'd0;
    pd_trig = 1'b0; xorsum = 32'd0;
    trig_per = 0; trig_ofs = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phwrite", 32'(phwrite), 32'd0);
    chk("rst_phdata", 32'(phdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_best_phase", 32'(best_phase), 32'd0);
    chk("rst_best_sum", best_sum, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // start and abort together in IDLE: abort wins
    chan_mask = 4'b0001; settle = 4'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("startabort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("startabort_busy2", 32'(busy), 32'd0);
    chk("startabort_done", 32'(done), 32'd0);
    chk("startabort_phwrite", 32'(phwrite), 32'd0);

    // channel I minimum 5 at phases 3 and 4 -> tie keeps phase 3
    xs_tab = '{32'hAABBCC28, 32'hAABBCC1E, 32'hAABBCC0C, 32'hAABBCC05,
               32'hAABBCC05, 32'hAABBCC09, 32'hAABBCC14, 32'hAABBCC21};
    run_scan("single", 4'b0001, 4'd1, 0, 0, -1, -1, 1'b0, 400);
    chk("single_timeout", 32'(timeout), 32'd0);
    chk("single_done_cnt", done_n, 32'd1);
    chk("single_latency", done_cyc, 32'd46);
    chk("single_apply_n", apply_n, 32'd1);
    chk("single_apply_bits", 32'(apply_bits[0]), 32'h1);
    chk("single_apply_data", 32'(apply_data[0]), 32'd3);
    chk("single_best_phase", 32'(best_phase), 32'h0003);
    chk("single_best_sum", best_sum, 32'h00000005);
    chk("single_set_strobe", bad_set, 32'd0);
    chk("single_phdata_idle", bad_data, 32'd0);
    chk("single_busy_after", 32'(busy), 32'd0);

    // channels II (min 10 at 6) and IV (min 3 at 1, tie at 3)
    xs_tab = '{32'h5A023201, 32'h03022801, 32'h07021E01, 32'h03022301,
               32'h08021401, 32'h09021901, 32'h04020A01, 32'h3C020F01};
    run_scan("pair", 4'b1010, 4'd2, 3, 0, -1, -1, 1'b0, 800);
    chk("pair_timeout", 32'(timeout), 32'd0);
    chk("pair_done_cnt", done_n, 32'd1);
    chk("pair_apply_n", apply_n, 32'd2);
    chk("pair_apply0_bits", 32'(apply_bits[0]), 32'h2);
    chk("pair_apply0_data", 32'(apply_data[0]), 32'd6);
    chk("pair_apply1_bits", 32'(apply_bits[1]), 32'h8);
    chk("pair_apply1_data", 32'(apply_data[1]), 32'd1);
    chk("pair_strobe_or", 32'(strobe_or), 32'hA);
    chk("pair_best_phase", 32'(best_phase), 32'h1060);
    chk("pair_best_sum", best_sum, 32'h03000A00);
    chk("pair_set_strobe", bad_set, 32'd0);

    // empty mask completes in two cycles with no strobes
    run_scan("empty", 4'b0000, 4'd3, 0, 0, -1, -1, 1'b0, 20);
    chk("empty_timeout", 32'(timeout), 32'd0);
    chk("empty_latency", done_cyc, 32'd2);
    chk("empty_done_cnt", done_n, 32'd1);
    chk("empty_strobe_or", 32'(strobe_or), 32'd0);
    chk("empty_best_sum", best_sum, 32'd0);

    // abort in SETTLE at phase 4: best reflects phases 0..3 only
    xs_tab = '{32'h00000028, 32'h0000001E, 32'h0000000C, 32'h00000014,
               32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
    run_scan("abort", 4'b0001, 4'd2, 4, 0, 4, -1, 1'b0, 400);
    chk("abort_timeout", 32'(timeout), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_phwrite", 32'(phwrite), 32'd0);
    repeat (20) step();
    chk("abort_no_done", done_n, 32'd0);
    chk("abort_best_phase", 32'(best_phase), 32'h0002);
    chk("abort_best_sum", best_sum, 32'h0000000C);
    run_scan("rerun", 4'b0001, 4'd2, 4, 0, -1, -1, 1'b0, 800);
    chk("rerun_timeout", 32'(timeout), 32'd0);
    chk("rerun_first_phase", first_ph, 32'd0);
    chk("rerun_done_cnt", done_n, 32'd1);
    chk("rerun_best_phase", 32'(best_phase), 32'h0004);
    chk("rerun_best_sum", best_sum, 32'h00000001);

    // second start mid-scan is ignored; reset during APPLY clears everything at once
    xs_tab = '{32'h00000028, 32'h0000001E, 32'h0000000C, 32'h00000005,
               32'h00000005, 32'h00000009, 32'h00000014, 32'h00000021};
    run_scan("restart", 4'b0001, 4'd1, 0, 0, -1, 2, 1'b1, 400);
    chk("restart_timeout", 32'(timeout), 32'd0);
    chk("restart_set_strobe", bad_set, 32'd0);
    chk("restart_apply_data", 32'(apply_data[0]), 32'd3);
    chk("restart_done_cnt", done_n, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("apply_rst_phwrite", 32'(phwrite), 32'd0);
    chk("apply_rst_phdata", 32'(phdata), 32'd0);
    chk("apply_rst_busy", 32'(busy), 32'd0);
    chk("apply_rst_done", 32'(done), 32'd0);
    chk("apply_rst_best_phase", 32'(best_phase), 32'd0);
    chk("apply_rst_best_sum", best_sum, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_phwrite", 32'(phwrite), 32'd0);

    // settle=0: one trigger wait per phase
    xs_tab = '{32'h5A023201, 32'h03022801, 32'h07021E01, 32'h03022301,
               32'h08021401, 32'h09021901, 32'h04020A01, 32'h3C020F01};
    run_scan("fast", 4'b1111, 4'd0, 0, 0, -1, -1, 1'b0, 200);
    chk("fast_timeout", 32'(timeout), 32'd0);
    chk("fast_latency", done_cyc, 32'd38);
    chk("fast_best_phase", 32'(best_phase), 32'h1060);
    chk("fast_best_sum", best_sum, 32'h03020A01);
    run_scan("trig16", 4'b1111, 4'd0, 16, 8, -1, -1, 1'b0, 400);
    chk("trig16_timeout", 32'(timeout), 32'd0);
    chk("trig16_latency", done_cyc, 32'd128);
    chk("trig16_apply_n", apply_n, 32'd4);
    chk("trig16_best_phase", 32'(best_phase), 32'h1060);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
